// File: rtl/ac_pkg.sv
// Shared definitions for the air-conditioning controller and its room plant model.
// The controller bench reuses the mode enum and temperature limits.
package ac_pkg;

  localparam int TEMP_W = 5;
  localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } ac_mode_t;

  // Conflicting commands (both high) fall back to IDLE.
  function automatic ac_mode_t decode_mode(input logic heat, input logic cool);
    if (heat && !cool) return HEAT;
    if (cool && !heat) return COOL;
    return IDLE;
  endfunction

endpackage

// File: rtl/room_thermal_model_step_timer.sv
// Period counter: counts 0..last, ticks on the terminal count, restarts on request.
// A restart discards any partial period and suppresses the tick.
module step_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [7:0] last,
  output logic       tick
);

  logic [7:0] cnt;

  assign tick = !restart && (cnt == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (restart || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/room_thermal_model.sv
// Room plant model: moves temperature one degree per period toward the commanded
// direction (saturating 0..31), or toward ambient when idle; flags heat/cool conflicts.
module room_thermal_model
  import ac_pkg::*;
#(
  parameter int INIT_TEMP = 20,
  parameter int AMBIENT   = 18,
  parameter int RATE_DIV  = 4,
  parameter int DRIFT_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              heat,
  input  logic              cool,
  output logic [TEMP_W-1:0] temperature,
  output logic              step,
  output logic              conflict
);

  localparam logic [7:0]        RATE_LAST  = 8'(RATE_DIV - 1);
  localparam logic [7:0]        DRIFT_LAST = 8'(DRIFT_DIV - 1);
  localparam logic [TEMP_W-1:0] INIT_T     = TEMP_W'(INIT_TEMP);
  localparam logic [TEMP_W-1:0] AMB_T      = TEMP_W'(AMBIENT);

  ac_mode_t          mode;
  ac_mode_t          mode_q;
  logic [7:0]        period_last;
  logic              tick;
  logic              changed;
  logic [TEMP_W-1:0] temp_nxt;

  assign mode        = decode_mode(heat, cool);
  assign period_last = (mode == IDLE) ? DRIFT_LAST : RATE_LAST;

  step_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (mode != mode_q),
    .last    (period_last),
    .tick    (tick)
  );

  always_comb begin
    temp_nxt = temperature;
    case (mode)
      HEAT: if (temperature != TEMP_MAX) temp_nxt = temperature + 5'd1;
      COOL: if (temperature != '0) temp_nxt = temperature - 5'd1;
      default: begin
        if (temperature < AMB_T) temp_nxt = temperature + 5'd1;
        else if (temperature > AMB_T) temp_nxt = temperature - 5'd1;
      end
    endcase
  end

  // Saturated or at-ambient attempts leave temperature alone and produce no pulse.
  assign changed = tick && (temp_nxt != temperature);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= IDLE;
      temperature <= INIT_T;
      step        <= 1'b0;
      conflict    <= 1'b0;
    end else begin
      mode_q   <= mode;
      step     <= changed;
      conflict <= conflict | (heat & cool);
      if (changed) temperature <= temp_nxt;
    end
  end

endmodule

// File: doc/room_thermal_model.md
# room_thermal_model

Synthesisable plant model that closes the loop around the air-conditioning controller. It consumes the controller's `heat`/`cool` commands and produces the 5-bit room temperature the controller samples. Temperature rises or falls at a fixed command rate and drifts toward ambient when undriven. It sits opposite the `ac` block in the top-level and closed-loop benches, replacing hand-driven `temperature` stimulus.

## Interface
Parameters:
- `INIT_TEMP`, 20: temperature loaded on reset (0..31).
- `AMBIENT`, 18: passive drift target (0..31).
- `RATE_DIV`, 4: cycles per 1-degree step while heating/cooling (1..256).
- `DRIFT_DIV`, 16: cycles per 1-degree step while idle (1..256).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `heat`  in  1  heat command from controller.
- `cool`  in  1  cool command from controller.
- `temperature`  out  5  current room temperature, unsigned degrees.
- `step`  out  1  one-cycle pulse on the edge `temperature` changes.
- `conflict`  out  1  sticky flag, set when `heat` and `cool` are sampled both high.

## Operation
- Decoded mode each edge: `heat & ~cool` gives HEAT; `cool & ~heat` gives COOL; otherwise IDLE. Both high decodes to IDLE and sets `conflict`.
- Registered state: `mode_q` (IDLE/HEAT/COOL), `cnt` (8-bit), `temperature`, `step`, `conflict`.
- Reset: `mode_q`=IDLE, `cnt`=0, `temperature`=INIT_TEMP, `step`=0, `conflict`=0. Reset has priority over all other updates.
- Period P is RATE_DIV in HEAT/COOL and DRIFT_DIV in IDLE.
- Each edge, with decoded mode M:
  - If M differs from `mode_q`: `mode_q`<=M, `cnt`<=0, no step.
  - Else if `cnt`==P-1: `cnt`<=0 and attempt a step.
  - Else `cnt`<=`cnt`+1, no step.
- Step attempt:
  - HEAT: +1, saturating at 31.
  - COOL: -1, saturating at 0.
  - IDLE: one degree toward AMBIENT; none if equal.
- `step`=1 for exactly the cycle after an edge that changed `temperature`. Saturated or at-ambient attempts give no pulse.
- `conflict` stays set until `rst`.

## Timing
- Inputs are sampled on the rising edge. `temperature` is registered with no combinational path from inputs.
- Command held from its first sampled edge (mode change on edge 1):
  - First step on edge P+1, then every P edges.
  - Exception: after reset, `mode_q` is already IDLE, so idle drift first steps on edge DRIFT_DIV.
- Any mode change, including a glitch of a single cycle, restarts `cnt`. A partial period is lost and not accumulated.
- RATE_DIV=1: steps every edge after the mode-change edge.
- `rst` mid-operation: next edge restores all reset values. Counting restarts from IDLE.
- `conflict` is visible one edge after the conflicting sample.

## Structure
- Shared package `ac_pkg`:
  - `TEMP_W`=5.
  - `TEMP_MAX`=31.
  - Mode enum `ac_mode_t` {IDLE, HEAT, COOL}. The controller bench reuses it.
- One natural sub-module, `step_timer`: `cnt` with restart/terminal-count logic, taking the period as an input and outputting a `tick`. Top level holds mode decode, saturating update and flags.

## Test plan
Defaults throughout.
- Reset, idle: `temperature`=20, `step`=0, `conflict`=0 after reset. Edge 16 gives 19 with a `step` pulse; edge 32 gives 18. Stays 18 with no further pulses for 100 cycles.
- Heat held from reset: 21, 22, 23 on edges 5, 9, 13. Reaches 31, then holds with no `step` pulses for 20 further cycles.
- Cool held from `temperature`=2: reaches 0 after the expected edges, then saturates with no pulses. Release to idle: first drift to 1 after 1+16 edges.
- Heat for 3 edges, then cool held: no change during heat. First decrement on the 5th cool edge; previous heat cycles do not count.
- Heat and cool both high for 1 cycle: `conflict`=1 the next cycle and stays 1 after release. Mode is IDLE and `cnt` restarts. Only `rst` clears it.
- `rst` pulsed while heating at 25 mid-period: next edge `temperature`=20, `step`=0. The first drift step comes 16 edges after reset release.
